device_req_arbiter: RTL and testbench

- Shares the single simulation device port (DPI device-helper request/response interface) among N_REQ requesters, e.g. per-core uncached MMIO paths.
- Round-robin arbitration; at most one request in flight at a time.
- Sequences every transaction as: accept, one-cycle device request, response returned to the winner under a valid/ready handshake.
- Sits between the requester MMIO ports and the device-helper instance in the simulation top.

---
 rtl/device_arb_pkg.sv | 27 ++
 rtl/device_req_arbiter_rr_picker.sv | 36 +++
 rtl/device_req_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_device_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/device_arb_pkg.sv
// Shared types and constants for the device request arbiter.
// FSM encodings, bus widths and the default legal device address window.
package device_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_ADDR_BASE = 32'h4060_0000;
    localparam logic [ADDR_W-1:0] DEFAULT_ADDR_SIZE = 32'h0010_0000;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t RESP  = 2'd2;

    // Unsigned wrap makes addresses below base fall out of the window
    function automatic logic addr_in_window(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input logic [ADDR_W-1:0] size);
        logic [ADDR_W-1:0] offset;
        offset = addr - base;
        return offset < size;
    endfunction

endpackage

// File: rtl/device_req_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search, starting one past rr_ptr and wrapping.
// Produces a one-hot grant, the winning index and an any-request flag.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    assign any = |req;

    // Walk from the farthest offset to the nearest so the nearest valid request wins
    always_comb begin
        grant    = '0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            cand     = (int'(rr_ptr) + k) % int'(N_REQ);
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/device_req_arbiter.sv
// Round-robin arbiter sharing the single simulation device port among N_REQ requesters.
// Define DEVICE_ARB_ADDR_CHECK_EN to reject accesses outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE).
module device_req_arbiter
    import device_arb_pkg::*;
#(
    parameter int unsigned       N_REQ     = 4,
    parameter logic [ADDR_W-1:0] ADDR_BASE = DEFAULT_ADDR_BASE,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_wen,
    input  logic [ADDR_W*N_REQ-1:0]  req_addr,
    input  logic [DATA_W*N_REQ-1:0]  req_wdata,
    input  logic [MASK_W*N_REQ-1:0]  req_wmask,
    output logic [N_REQ-1:0]         resp_valid,
    input  logic [N_REQ-1:0]         resp_ready,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_err,
    output logic                     dev_req_valid,
    output logic                     dev_req_wen,
    output logic [ADDR_W-1:0]        dev_req_addr,
    output logic [DATA_W-1:0]        dev_req_wdata,
    output logic [MASK_W-1:0]        dev_req_wmask,
    input  logic [DATA_W-1:0]        dev_resp_rdata
);

    localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  win_grant_q, win_grant_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];
    logic [MASK_W-1:0] wmask_arr [N_REQ];

    logic accept;
    logic first_resp;
    logic handshake;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
        assign wmask_arr[g] = req_wmask[g*MASK_W +: MASK_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // No accept while reset is held, so a request cannot be lost in the reset cycle
    assign accept     = (state_q == IDLE) && pick_any && !reset;
    assign first_resp = (state_q == RESP) && (resp_valid_q == '0);
    assign handshake  = (state_q == RESP) && (|(resp_valid_q & resp_ready));

    assign req_ready = accept ? pick_grant : '0;

`ifdef DEVICE_ARB_ADDR_CHECK_EN
    logic in_range;
    logic resp_err_q, resp_err_d;

    assign in_range = addr_in_window(addr_arr[pick_idx], ADDR_BASE, ADDR_SIZE);

    always_comb begin
        resp_err_d = resp_err_q;
        if (accept) begin
            resp_err_d = !in_range;
        end else if (handshake) begin
            resp_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;
`else
    logic [2*ADDR_W-1:0] unused_addr_window;

    assign unused_addr_window = {ADDR_BASE, ADDR_SIZE};
    assign resp_err           = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_grant_d  = win_grant_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rr_ptr_d    = pick_idx;
                    win_grant_d = pick_grant;
                    wen_d       = req_wen[pick_idx];
                    addr_d      = addr_arr[pick_idx];
                    wdata_d     = wdata_arr[pick_idx];
                    wmask_d     = wmask_arr[pick_idx];
                    state_d     = ISSUE;
`ifdef DEVICE_ARB_ADDR_CHECK_EN
                    // Rejected accesses never reach the device and answer immediately
                    if (!in_range) begin
                        state_d      = RESP;
                        resp_valid_d = pick_grant;
                        resp_rdata_d = '0;
                    end
`endif
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                if (first_resp) begin
                    resp_rdata_d = dev_resp_rdata;
                    resp_valid_d = win_grant_q;
                end else if (handshake) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= LAST_IDX;
            win_grant_q  <= '0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_grant_q  <= win_grant_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Gated by reset so an ISSUE interrupted by reset never reaches the device
    assign dev_req_valid = (state_q == ISSUE) && !reset;
    assign dev_req_wen   = wen_q;
    assign dev_req_addr  = addr_q;
    assign dev_req_wdata = wdata_q;
    assign dev_req_wmask = wmask_q;

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_device_req_arbiter.sv
// Directed testbench for device_req_arbiter with hand-computed expectations.
// Compile with +define+DEVICE_ARB_ADDR_CHECK_EN to also exercise the address window check.
module tb_device_req_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wen;
    logic [32*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [4*N-1:0]  req_wmask;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [31:0]     resp_rdata;
    logic            resp_err;
    logic            dev_req_valid;
    logic            dev_req_wen;
    logic [31:0]     dev_req_addr;
    logic [31:0]     dev_req_wdata;
    logic [3:0]      dev_req_wmask;
    logic [31:0]     dev_resp_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    device_req_arbiter #(
        .N_REQ     (N),
        .ADDR_BASE (32'h4060_0000),
        .ADDR_SIZE (32'h0010_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .dev_req_valid  (dev_req_valid),
        .dev_req_wen    (dev_req_wen),
        .dev_req_addr   (dev_req_addr),
        .dev_req_wdata  (dev_req_wdata),
        .dev_req_wmask  (dev_req_wmask),
        .dev_resp_rdata (dev_resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr_tab [N];
        logic [3:0]  exp_g;

        addr_tab[0] = 32'h4060_0000;
        addr_tab[1] = 32'h4060_0020;
        addr_tab[2] = 32'h4060_0010;
        addr_tab[3] = 32'h4060_0030;

        reset          = 1'b1;
        req_valid      = '0;
        req_wen        = '0;
        req_addr       = '0;
        req_wdata      = '0;
        req_wmask      = '0;
        resp_ready     = 4'hF;
        dev_resp_rdata = '0;

        // Reset state
        step();
        step();
        mid();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_dev_valid", 32'(dev_req_valid), 32'h0);
        step();
        reset = 1'b0;
        mid();
        check("idle_resp_rdata", resp_rdata, 32'h0);
        check("idle_resp_err", 32'(resp_err), 32'h0);
        check("idle_dev_addr", dev_req_addr, 32'h0);
        check("idle_req_ready", 32'(req_ready), 32'h0);
        step();

        // Single read from requester 0
        req_valid      = 4'b0001;
        req_addr[31:0] = 32'h4060_0000;
        dev_resp_rdata = 32'hDEAD_BEEF;
        mid();
        check("rd_accept", 32'(req_ready), 32'h1);
        check("rd_accept_dev_valid", 32'(dev_req_valid), 32'h0);
        step();
        req_valid = '0;
        mid();
        check("rd_issue_valid", 32'(dev_req_valid), 32'h1);
        check("rd_issue_addr", dev_req_addr, 32'h4060_0000);
        check("rd_issue_wen", 32'(dev_req_wen), 32'h0);
        check("rd_issue_ready", 32'(req_ready), 32'h0);
        step();
        mid();
        check("rd_capture_dev_valid", 32'(dev_req_valid), 32'h0);
        check("rd_capture_resp_valid", 32'(resp_valid), 32'h0);
        step();
        mid();
        check("rd_resp_valid", 32'(resp_valid), 32'h1);
        check("rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("rd_resp_err", 32'(resp_err), 32'h0);
        step();
        mid();
        check("rd_done", 32'(resp_valid), 32'h0);
        step();

        // Write from requester 2 (rr_ptr=0, search 1,2)
        req_valid        = 4'b0100;
        req_wen          = 4'b0100;
        req_addr[95:64]  = 32'h4060_0010;
        req_wdata[95:64] = 32'h1234_5678;
        req_wmask[11:8]  = 4'b0011;
        dev_resp_rdata   = 32'hA5A5_0001;
        mid();
        check("wr_accept", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        req_wen   = '0;
        mid();
        check("wr_issue_valid", 32'(dev_req_valid), 32'h1);
        check("wr_issue_wen", 32'(dev_req_wen), 32'h1);
        check("wr_issue_addr", dev_req_addr, 32'h4060_0010);
        check("wr_issue_wdata", dev_req_wdata, 32'h1234_5678);
        check("wr_issue_wmask", 32'(dev_req_wmask), 32'h3);
        step();
        step();
        mid();
        check("wr_ack_valid", 32'(resp_valid), 32'h4);
        check("wr_ack_rdata", resp_rdata, 32'hA5A5_0001);
        step();

        // Backpressure on requester 1 (rr_ptr=2, search 3,0,1)
        req_valid       = 4'b0010;
        resp_ready      = 4'b1101;
        req_addr[63:32] = 32'h4060_0020;
        dev_resp_rdata  = 32'hCAFE_0001;
        mid();
        check("bp_accept", 32'(req_ready), 32'h2);
        step();
        req_valid         = 4'b1000;
        req_addr[127:96]  = 32'h4060_0030;
        mid();
        check("bp_issue_valid", 32'(dev_req_valid), 32'h1);
        check("bp_issue_ready", 32'(req_ready), 32'h0);
        step();
        mid();
        check("bp_capture_ready", 32'(req_ready), 32'h0);
        step();
        dev_resp_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 10; i++) begin
            mid();
            check("bp_hold_valid", 32'(resp_valid), 32'h2);
            check("bp_hold_rdata", resp_rdata, 32'hCAFE_0001);
            check("bp_hold_ready", 32'(req_ready), 32'h0);
            check("bp_hold_dev_valid", 32'(dev_req_valid), 32'h0);
            step();
        end
        resp_ready = 4'hF;
        mid();
        check("bp_release_valid", 32'(resp_valid), 32'h2);
        step();
        mid();
        check("bp_done_valid", 32'(resp_valid), 32'h0);
        check("bp_next_accept", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        mid();
        check("r3_issue_addr", dev_req_addr, 32'h4060_0030);
        check("r3_issue_valid", 32'(dev_req_valid), 32'h1);
        step();
        step();
        mid();
        check("r3_resp_valid", 32'(resp_valid), 32'h8);
        check("r3_resp_rdata", resp_rdata, 32'h0BAD_0BAD);
        step();

        // Contention: all four valid from reset, served 0,1,2,3,0 four cycles apart
        reset            = 1'b1;
        req_valid        = 4'hF;
        req_addr[31:0]   = addr_tab[0];
        req_addr[63:32]  = addr_tab[1];
        req_addr[95:64]  = addr_tab[2];
        req_addr[127:96] = addr_tab[3];
        dev_resp_rdata   = 32'h1111_2222;
        mid();
        check("ct_reset_ready", 32'(req_ready), 32'h0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            mid();
            check("ct_grant", 32'(req_ready), 32'(exp_g));
            step();
            mid();
            check("ct_issue_addr", dev_req_addr, addr_tab[k % 4]);
            check("ct_issue_valid", 32'(dev_req_valid), 32'h1);
            step();
            mid();
            check("ct_wait_ready", 32'(req_ready), 32'h0);
            step();
            mid();
            check("ct_resp_valid", 32'(resp_valid), 32'(exp_g));
            check("ct_resp_ready", 32'(req_ready), 32'h0);
            step();
        end
        req_valid = '0;

        // Reset in ISSUE (rr_ptr=0, requester 1 wins first)
        req_valid = 4'b0010;
        mid();
        check("ri_accept", 32'(req_ready), 32'h2);
        step();
        reset     = 1'b1;
        req_valid = '0;
        mid();
        check("ri_dev_valid", 32'(dev_req_valid), 32'h0);
        step();
        reset     = 1'b0;
        req_valid = 4'b0101;
        mid();
        check("ri_resp_valid", 32'(resp_valid), 32'h0);
        check("ri_resp_rdata", resp_rdata, 32'h0);
        check("ri_dev_addr", dev_req_addr, 32'h0);
        check("ri_dev_valid_after", 32'(dev_req_valid), 32'h0);
        check("ri_next_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        step();
        mid();
        check("ri_resp_after", 32'(resp_valid), 32'h1);
        check("ri_rdata_after", resp_rdata, 32'h1111_2222);
        step();

`ifdef DEVICE_ARB_ADDR_CHECK_EN
        // Address below the window wraps and is rejected without a device request
        req_valid      = 4'b0001;
        req_addr[31:0] = 32'h3FFF_FFFC;
        mid();
        check("ac_accept", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        mid();
        check("ac_dev_valid", 32'(dev_req_valid), 32'h0);
        check("ac_resp_valid", 32'(resp_valid), 32'h1);
        check("ac_resp_err", 32'(resp_err), 32'h1);
        check("ac_resp_rdata", resp_rdata, 32'h0);
        step();
        mid();
        check("ac_done_valid", 32'(resp_valid), 32'h0);
        check("ac_done_err", 32'(resp_err), 32'h0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
